// File: rtl/dff_write_arbiter.sv
// Four-requester round-robin write arbiter in front of a shared WIDTH-bit register.
// Each write takes an IDLE arbitration cycle followed by a one-cycle GRANT.
module dff_write_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [3:0]         req,
  input  logic [4*WIDTH-1:0] wdata,
  output logic [3:0]         gnt,
  output logic [WIDTH-1:0]   q,
  output logic               q_valid,
  output logic               busy,
  output logic [7:0]         wr_count
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state_reg, state_next;
  logic [1:0]       ptr_reg;
  logic [1:0]       sel_reg;
  logic [1:0]       sel;
  logic [1:0]       idx;
  logic [WIDTH-1:0] q_reg;
  logic             q_valid_reg;
  logic [7:0]       wr_count_reg;
  logic             commit;
  logic [WIDTH-1:0] lane [4];

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign lane[gi] = wdata[gi*WIDTH +: WIDTH];
      // Grant is visible only while the latched requester keeps asking.
      assign gnt[gi]  = busy && (sel_reg == 2'(gi)) && req[gi];
    end
  endgenerate

  // Walk the search order backwards so the entry closest to ptr wins.
  always_comb begin
    sel = ptr_reg;
    idx = ptr_reg;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr_reg + 2'(k);
      if (req[idx]) sel = idx;
    end
  end

  assign commit = (state_reg == GRANT) && req[sel_reg];

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (|req) state_next = GRANT;
      GRANT:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      ptr_reg      <= 2'd0;
      sel_reg      <= 2'd0;
      q_reg        <= '0;
      q_valid_reg  <= 1'b0;
      wr_count_reg <= 8'd0;
    end else begin
      state_reg   <= state_next;
      q_valid_reg <= commit;
      if (state_reg == IDLE && |req) sel_reg <= sel;
      // An aborted grant leaves data, count and pointer untouched.
      if (commit) begin
        q_reg        <= lane[sel_reg];
        wr_count_reg <= wr_count_reg + 8'd1;
        ptr_reg      <= sel_reg + 2'd1;
      end
    end
  end

  assign busy     = (state_reg == GRANT);
  assign q        = q_reg;
  assign q_valid  = q_valid_reg;
  assign wr_count = wr_count_reg;

endmodule

// File: tb/tb_dff_write_arbiter.sv
// Directed bench for dff_write_arbiter: reset, single write, round-robin,
// pointer rotation, abort, reset during GRANT and counter wrap.
module tb_dff_write_arbiter;

  localparam int WIDTH = 8;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [3:0]         req;
  logic [4*WIDTH-1:0] wdata;
  logic [3:0]         gnt;
  logic [WIDTH-1:0]   q;
  logic               q_valid;
  logic               busy;
  logic [7:0]         wr_count;

  int checks = 0;
  int errors = 0;

  dff_write_arbiter #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .wdata    (wdata),
    .gnt      (gnt),
    .q        (q),
    .q_valid  (q_valid),
    .busy     (busy),
    .wr_count (wr_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    $display("check %-18s observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic set_lane(input int i, input logic [7:0] v);
    wdata[i*WIDTH +: WIDTH] = v;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 4'b0000;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 4'b0000;
    wdata = '0;

    // Reset state
    do_reset();
    check("rst_q",        32'(q),        32'h0);
    check("rst_q_valid",  32'(q_valid),  32'h0);
    check("rst_wr_count", 32'(wr_count), 32'h0);
    check("rst_gnt",      32'(gnt),      32'h0);
    check("rst_busy",     32'(busy),     32'h0);

    // Single write: gnt one cycle after req, q the cycle after that
    req = 4'b0001;
    set_lane(0, 8'hA5);
    check("idle_gnt", 32'(gnt), 32'h0);
    tick();
    check("single_gnt",  32'(gnt),     32'h1);
    check("single_busy", 32'(busy),    32'h1);
    check("single_qv0",  32'(q_valid), 32'h0);
    tick();
    req = 4'b0000;
    check("single_q",    32'(q),        32'hA5);
    check("single_qv",   32'(q_valid),  32'h1);
    check("single_cnt",  32'(wr_count), 32'h1);
    check("single_busy0",32'(busy),     32'h0);
    tick();
    check("single_qv_drop", 32'(q_valid), 32'h0);

    // Round-robin from reset with all four requesting
    do_reset();
    set_lane(0, 8'h10);
    set_lane(1, 8'h20);
    set_lane(2, 8'h30);
    set_lane(3, 8'h40);
    req = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("rr_gnt%0d", i), 32'(gnt), 32'(4'b0001 << i));
      tick();
      req[i] = 1'b0;
      check($sformatf("rr_q%0d", i), 32'(q), 32'(8'h10 * (i + 1)));
      check($sformatf("rr_gnt_idle%0d", i), 32'(gnt), 32'h0);
    end
    check("rr_cnt", 32'(wr_count), 32'h4);

    // Commit to requester 2, then 0101 must pick requester 0 (order 3,0,1,2)
    req = 4'b0100;
    set_lane(2, 8'h55);
    tick();
    check("rot_gnt2", 32'(gnt), 32'h4);
    tick();
    req = 4'b0101;
    set_lane(0, 8'h66);
    check("rot_q2", 32'(q), 32'h55);
    tick();
    check("rot_gnt0", 32'(gnt), 32'h1);
    tick();
    req = 4'b0000;
    check("rot_q0",   32'(q),        32'h66);
    check("rot_cnt",  32'(wr_count), 32'h6);

    // Abort: requester 1 selected, drops req during GRANT
    req = 4'b0010;
    set_lane(1, 8'h77);
    tick();
    req = 4'b0000;
    #1;
    check("abort_gnt",  32'(gnt),  32'h0);
    check("abort_busy", 32'(busy), 32'h1);
    tick();
    check("abort_q",   32'(q),        32'h66);
    check("abort_qv",  32'(q_valid),  32'h0);
    check("abort_cnt", 32'(wr_count), 32'h6);
    // Pointer still 1: 0011 must pick requester 1, not 0
    req = 4'b0011;
    set_lane(1, 8'h88);
    tick();
    check("abort_next_gnt", 32'(gnt), 32'h2);
    // Other requesters changing during GRANT do not move the grant
    req = 4'b0110;
    #1;
    check("grant_hold", 32'(gnt), 32'h2);
    tick();
    req = 4'b0000;
    check("abort_next_q",   32'(q),        32'h88);
    check("abort_next_cnt", 32'(wr_count), 32'h7);
    tick();

    // Reset during GRANT of a lane-3 write discards it
    do_reset();
    req = 4'b1000;
    set_lane(3, 8'hFF);
    tick();
    check("midrst_gnt", 32'(gnt), 32'h8);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    req   = 4'b0000;
    check("midrst_q",    32'(q),        32'h0);
    check("midrst_cnt",  32'(wr_count), 32'h0);
    check("midrst_busy", 32'(busy),     32'h0);
    check("midrst_gnt0", 32'(gnt),      32'h0);
    check("midrst_qv",   32'(q_valid),  32'h0);

    // Counter wrap with a continuous request (IDLE/GRANT alternate)
    do_reset();
    req = 4'b0001;
    for (int i = 0; i < 256; i++) begin
      set_lane(0, 8'(i));
      tick();
      tick();
      if (i == 254) check("wrap_cnt255", 32'(wr_count), 32'hFF);
    end
    check("wrap_cnt0", 32'(wr_count), 32'h0);
    check("wrap_q",    32'(q),        32'hFF);
    set_lane(0, 8'h3C);
    tick();
    check("wrap_busy", 32'(busy), 32'h1);
    tick();
    req = 4'b0000;
    check("wrap_cnt1", 32'(wr_count), 32'h1);
    check("wrap_q257", 32'(q),        32'h3C);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dff_write_arbiter.md
DFF_WRITE_ARBITER -- requirements
Module: dff_write_arbiter

Interface
REQ-001 Parameter WIDTH, default 8: width of the shared data register and of each requester's data lane.
REQ-002 clk  input  1  the only clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-low; sampled on the rising edge of clk.
REQ-004 req  input  4  per-requester write request; bit i belongs to requester i.
REQ-005 wdata  input  4*WIDTH  flattened write data; requester i owns wdata[i*WIDTH +: WIDTH].
REQ-006 gnt  output  4  one-hot grant; at most one bit high in any cycle.
REQ-007 q  output  WIDTH  shared D-flip-flop bank contents.
REQ-008 q_valid  output  1  one-cycle pulse: q was updated at the preceding edge.
REQ-009 busy  output  1  high while the FSM is in GRANT.
REQ-010 wr_count  output  8  count of committed writes, wraps 255 -> 0.

Function
REQ-011 FSM SHALL have exactly two states: IDLE and GRANT.
REQ-012 In IDLE with req != 0, the block SHALL select requester sel by round-robin from pointer ptr: first i in order ptr, ptr+1, ..., ptr+3 (mod 4) with req[i]=1.
REQ-013 At the edge ending that IDLE cycle: state -> GRANT; sel_r <= sel.
REQ-014 In IDLE with req == 0, the FSM SHALL stay in IDLE with no register change except q_valid <= 0.
REQ-015 In GRANT, gnt SHALL equal onehot(sel_r) AND req: the grant is shown only while the selected requester still requests.
REQ-016 In GRANT with req[sel_r]=1 (commit), the following SHALL happen at the closing edge:
  - q <= wdata lane sel_r, sampled in the GRANT cycle
  - q_valid <= 1
  - wr_count <= wr_count+1
  - ptr <= (sel_r+1) mod 4
REQ-017 In GRANT with req[sel_r]=0 (abort):
  - gnt SHALL be 0
  - q, wr_count and ptr SHALL be unchanged
  - q_valid <= 0
REQ-018 GRANT SHALL always last exactly one cycle and return to IDLE, commit or abort.
REQ-019 Latency: req rising in cycle N (FSM in IDLE) -> gnt high in cycle N+1 -> q updated and q_valid high in cycle N+2.
REQ-020 Throughput: at most one write per two cycles; continuous requests SHALL alternate IDLE and GRANT.
REQ-021 Requester protocol: hold req and data lane stable until gnt is seen; deassert at the edge ending the gnt cycle.
REQ-022 Changes to req bits other than sel_r during GRANT SHALL NOT affect the current grant; they are arbitrated in the next IDLE.
REQ-023 Fairness: with all four req held high, grants SHALL cycle 0,1,2,3,0,... from reset.
REQ-024 busy SHALL be high exactly in GRANT cycles; gnt SHALL be 0 in every IDLE cycle.
REQ-025 wr_count SHALL wrap from 255 to 0 with no flag.

Reset
REQ-026 On a rising edge with rst_n=0, the block SHALL set:
  - state = IDLE, ptr = 0, sel_r = 0
  - q = 0, q_valid = 0, wr_count = 0
  - gnt = 0, busy = 0
REQ-027 Reset asserted during GRANT SHALL discard that write: q stays 0, wr_count stays 0.
REQ-028 Reset SHALL take priority over every other event in the same cycle.

Verification
REQ-029 Single write: reset, then req=4'b0001, lane0=8'hA5 -> gnt=0001 one cycle later; next cycle q=8'hA5, q_valid=1, wr_count=1.
REQ-030 Round-robin: req=4'b1111, lanes 8'h10/8'h20/8'h30/8'h40, each requester drops req after its grant -> gnt order 0,1,2,3; q=8'h10,8'h20,8'h30,8'h40; wr_count=4.
REQ-031 Pointer rotation: after a committed grant to requester 2, req=4'b0101 -> requester 0 is granted (search order 3,0,1,2).
REQ-032 Abort: requester 1 selected, req[1] dropped in the GRANT cycle -> gnt=0000, q and wr_count unchanged; next grant still starts the search at the old ptr.
REQ-033 Reset mid-op: rst_n=0 in the GRANT cycle of a lane-3 write of 8'hFF -> next cycle q=0, wr_count=0, state IDLE, gnt=0.
REQ-034 Wrap: 256 committed writes from reset -> wr_count=0; the 257th write -> wr_count=1.
